// File: rtl/wide_ff_ser_pkg.sv
// Shared types for the wide-word serializer: FSM state encoding and counter sizing.
// The PARITY state is only reachable when WIDE_FF_SER_PARITY_EN is defined.
package wide_ff_ser_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SHIFT  = 2'd1;
    localparam logic [1:0] ENC_PARITY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SHIFT  = ENC_SHIFT,
        ST_PARITY = ENC_PARITY
    } ser_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer; start_i zeroes it at frame start or on return to idle.
// Holds at WIDTH-1 (no wrap) and flags that position through last_o.
module ser_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic start_i,
    input  logic inc_i,
    output logic last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last_o = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (start_i) begin
                cnt_d = '0;
            end else if (inc_i && !last_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wide_ff_serializer.sv
// Parallel-to-serial transmitter with valid/ready input, clock enable and gapless back-to-back frames.
// Define WIDE_FF_SER_PARITY_EN to append an even-parity bit to every frame.
module wide_ff_serializer
    import wide_ff_ser_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             ser_out_q, ser_out_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             last_cycle;
    logic             accept;
    logic             cnt_start;
    logic             cnt_inc;
`ifdef WIDE_FF_SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk_i   (clk),
        .rst_n_i (clr_n),
        .en_i    (en),
        .start_i (cnt_start),
        .inc_i   (cnt_inc),
        .last_o  (last_bit)
    );

`ifdef WIDE_FF_SER_PARITY_EN
    assign last_cycle = (state_q == ST_PARITY);
`else
    assign last_cycle = (state_q == ST_SHIFT) && last_bit;
`endif

    assign in_ready = en & ((state_q == ST_IDLE) | last_cycle);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        ser_out_d = ser_out_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        cnt_start = 1'b0;
        cnt_inc   = 1'b0;
`ifdef WIDE_FF_SER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (en) begin
            if (accept) begin
                // New word: first bit goes straight to the output register, rest parks in sr.
                state_d   = ST_SHIFT;
                ser_out_d = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
                sr_d      = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
                frame_d   = 1'b1;
                cnt_start = 1'b1;
                done_d    = last_cycle;
`ifdef WIDE_FF_SER_PARITY_EN
                parity_d  = ^in_data;
`endif
            end else if (last_cycle) begin
                state_d   = ST_IDLE;
                ser_out_d = IDLE_LEVEL;
                frame_d   = 1'b0;
                done_d    = 1'b1;
                cnt_start = 1'b1;
            end else if (state_q == ST_SHIFT) begin
`ifdef WIDE_FF_SER_PARITY_EN
                if (last_bit) begin
                    state_d   = ST_PARITY;
                    ser_out_d = parity_q;
                end else
`endif
                begin
                    ser_out_d = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
                    sr_d      = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                    cnt_inc   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            ser_out_q <= IDLE_LEVEL;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef WIDE_FF_SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ser_out_q <= ser_out_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
`ifdef WIDE_FF_SER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_frame = frame_q;
    assign done      = done_q;

endmodule
